console_ctrl: RTL

- Clocked, parametrised text-console controller. Takes a byte stream from the UART receiver and maintains the cursor. Writes characters into the character video RAM.
- Adds the following:
  - valid/ready handshake
  - configurable grid size
  - line wrap
  - hardware scroll via a row-offset register
  - clear-screen and clear-row fill engines
- Sits between the UART receiver and the VRAM write port. `top_row` feeds the video renderer.

---
 rtl/console_ctrl_if.sv | 34 +++
 rtl/console_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/console_ctrl_if.sv
// Console controller bus: UART byte handshake in, cursor/scroll state and VRAM write port out.
// Latency: none, this is wiring only.
// Backpressure: rx_ready from the controller gates acceptance of rx_data.
interface console_ctrl_if #(
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 13
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [CW-1:0]     cursor_x;
  logic [RW-1:0]     cursor_y;
  logic [RW-1:0]     top_row;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  // Byte source / VRAM sink side
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, cursor_x, cursor_y, top_row, busy, we, waddr, wdata
  );

  // Controller side
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, cursor_x, cursor_y, top_row, busy, we, waddr, wdata
  );
endinterface

// File: rtl/console_ctrl.sv
// Text console controller: decodes a byte stream into VRAM writes, cursor moves, scroll and fills.
// Latency: VRAM write is registered, one cycle after the accepting edge; cursor moves on that edge.
// Backpressure: rx_ready is low for the whole row/page fill; a held byte waits for the next IDLE cycle.
module console_ctrl #(
  parameter int COLS           = 40,
  parameter int ROWS           = 30,
  parameter int ADDR_W         = 13,
  parameter int TAB            = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst,
  console_ctrl_if.slave bus
);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW1   = CW + 1;
  localparam int RW1   = RW + 1;
  localparam int TOTAL = COLS * ROWS;

  localparam logic [7:0]        SPACE    = 8'h20;
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ALL_LAST = ADDR_W'(TOTAL - 1);
  localparam logic [CW-1:0]     X_MAX    = CW'(COLS - 1);
  localparam logic [RW-1:0]     Y_MAX    = RW'(ROWS - 1);
  localparam logic [RW:0]       ROWS_E   = RW1'(ROWS);
  localparam logic [CW:0]       COLS_E   = CW1'(COLS);
  localparam logic [CW:0]       TAB_MASK = CW1'(TAB - 1);

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  state_t            state;
  logic [CW-1:0]     cx;
  logic [RW-1:0]     cy;
  logic [RW-1:0]     top;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wdata_q;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] fill_cnt;

  // Next-state values for the byte currently offered on rx_data
  logic [CW-1:0]     nx;
  logic [RW-1:0]     ny;
  logic [RW-1:0]     ntop;
  state_t            nstate;
  logic              n_we;
  logic [ADDR_W-1:0] n_addr;
  logic [7:0]        n_data;
  logic              newline;
  logic [CW:0]       tab_next;
  logic [RW-1:0]     top_inc;

  // Logical (row, col) to VRAM address; the row wrap is a single compare/subtract
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] t,
                                                  input logic [RW-1:0] row,
                                                  input logic [CW-1:0] col);
    logic [RW:0] s;
    s = {1'b0, t} + {1'b0, row};
    if (s >= ROWS_E) s = s - ROWS_E;
    return ADDR_W'(s) * COLS_A + ADDR_W'(col);
  endfunction

  assign top_inc  = (top == Y_MAX) ? '0 : top + RW'(1);
  // Next tab stop strictly to the right: round x up past its TAB-aligned block
  assign tab_next = ({1'b0, cx} | TAB_MASK) + CW1'(1);

  // Decode the offered byte into cursor motion, an optional write and the follow-on state
  always_comb begin
    nx      = cx;
    ny      = cy;
    ntop    = top;
    nstate  = IDLE;
    n_we    = 1'b0;
    n_addr  = cell_addr(top, cy, cx);
    n_data  = bus.rx_data;
    newline = 1'b0;
    if (bus.rx_data >= 8'h20 && bus.rx_data <= 8'h7E) begin
      n_we = 1'b1;
      if (cx == X_MAX) newline = 1'b1;
      else             nx = cx + CW'(1);
    end else begin
      case (bus.rx_data)
        8'h0D: nx = '0;
        8'h0A: newline = 1'b1;
        8'h08, 8'h7F: begin
          if (cx != '0) begin
            nx     = cx - CW'(1);
            n_we   = 1'b1;
            n_data = SPACE;
            n_addr = cell_addr(top, cy, cx - CW'(1));
          end else if (cy != '0) begin
            nx     = X_MAX;
            ny     = cy - RW'(1);
            n_we   = 1'b1;
            n_data = SPACE;
            n_addr = cell_addr(top, cy - RW'(1), X_MAX);
          end
        end
        8'h09: begin
          if (tab_next >= COLS_E) newline = 1'b1;
          else                    nx = tab_next[CW-1:0];
        end
        8'h0C: begin
          nx     = '0;
          ny     = '0;
          ntop   = '0;
          nstate = CLR_ALL;
        end
        8'h11: if (cx != '0)    nx = cx - CW'(1);
        8'h12: if (cx != X_MAX) nx = cx + CW'(1);
        8'h13: if (cy != '0)    ny = cy - RW'(1);
        8'h14: if (cy != Y_MAX) ny = cy + RW'(1);
        default: ;
      endcase
    end
    // Newline at the bottom scrolls: the old top row becomes the new bottom row and gets blanked
    if (newline) begin
      nx = '0;
      if (cy != Y_MAX) begin
        ny = cy + RW'(1);
      end else begin
        ntop   = top_inc;
        nstate = CLR_ROW;
      end
    end
  end

  // Controller FSM: accepts bytes in IDLE, otherwise streams space fills to VRAM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
      cx        <= '0;
      cy        <= '0;
      top       <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      fill_base <= '0;
      fill_cnt  <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            cx        <= nx;
            cy        <= ny;
            top       <= ntop;
            state     <= nstate;
            we_q      <= n_we;
            fill_cnt  <= '0;
            // Only consumed on a scroll, where the old top row is the row to blank
            fill_base <= ADDR_W'(top) * COLS_A;
            if (n_we) begin
              waddr_q <= n_addr;
              wdata_q <= n_data;
            end
          end
        end
        CLR_ROW: begin
          we_q    <= 1'b1;
          waddr_q <= fill_base + fill_cnt;
          wdata_q <= SPACE;
          if (fill_cnt == ROW_LAST) begin
            fill_cnt <= '0;
            state    <= IDLE;
          end else begin
            fill_cnt <= fill_cnt + ADDR_W'(1);
          end
        end
        CLR_ALL: begin
          we_q    <= 1'b1;
          waddr_q <= fill_cnt;
          wdata_q <= SPACE;
          if (fill_cnt == ALL_LAST) begin
            fill_cnt <= '0;
            state    <= IDLE;
          end else begin
            fill_cnt <= fill_cnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.cursor_x = cx;
  assign bus.cursor_y = cy;
  assign bus.top_row  = top;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
endmodule
